// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//
// Bundles every non-clock signal of uart_tx_arbiter: the requester-side
// valid/ready byte handshake and the PISO-side launch/status signals.
//
//   req_valid   [NUM_REQ]    per-requester byte valid
//   req_data    [8*NUM_REQ]  requester i byte at [8i+7:8i]
//   req_ready   [NUM_REQ]    one-hot accept from the arbiter
//   send                     start request to the PISO
//   data_out    [8]          byte presented to the PISO
//   parity_out               parity presented to the PISO
//   active_flag              PISO transmitting
//   done_flag                PISO idle/done
//   grant_id    [ID_W]       requester owning the current frame
//   busy                     arbiter not in IDLE
//   timeout_err              sticky launch-timeout flag
//
// Modports:
//   master - the client/PISO side (drives requests and PISO status)
//   slave  - the arbiter itself
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 send;
    logic [7:0]           data_out;
    logic                 parity_out;
    logic                 active_flag;
    logic                 done_flag;
    logic [ID_W-1:0]      grant_id;
    logic                 busy;
    logic                 timeout_err;

    modport master (
        output req_valid,
        output req_data,
        output active_flag,
        output done_flag,
        input  req_ready,
        input  send,
        input  data_out,
        input  parity_out,
        input  grant_id,
        input  busy,
        input  timeout_err
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  active_flag,
        input  done_flag,
        output req_ready,
        output send,
        output data_out,
        output parity_out,
        output grant_id,
        output busy,
        output timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin scheduler sharing one UART PISO transmitter between NUM_REQ
// byte requesters. One byte is accepted per grant over valid/ready, its
// parity is computed, and exactly one PISO frame is launched for it by
// holding send until the PISO reports active_flag.
//
// Ports:
//   baud_clk  - sole clock (baud-rate clock shared with the PISO)
//   reset_n   - asynchronous, active-low reset
//   bus       - uart_tx_arbiter_if.slave (handshake + PISO signals)
//
// Parameters:
//   NUM_REQ    - number of requesters (2..8)
//   PARITY_ODD - 0: even parity (XOR of data), 1: odd parity (inverted XOR)
//   TIMEOUT    - cycles allowed from send assertion to active_flag
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   When defined, a launch counter aborts a frame whose PISO never goes
//   active within TIMEOUT cycles and sets the sticky timeout_err flag.
//   When undefined, WAIT_ACT waits indefinitely and timeout_err is 0.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter bit PARITY_ODD = 1'b0,
    parameter int TIMEOUT    = 16
) (
    input  logic             baud_clk,
    input  logic             reset_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Elaboration-time guards on the configuration range.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_ACT  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_q, rr_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [7:0]      data_q, data_d;
    logic            parity_q, parity_d;
    logic            send_q, send_d;
    logic            timeout_hit;

    // -----------------------------------------------------------------------
    // Per-lane data/parity and rotated scan order
    // -----------------------------------------------------------------------
    logic [7:0]         lane_data   [NUM_REQ];
    logic [NUM_REQ-1:0] lane_parity;
    logic [ID_W-1:0]    scan_idx    [NUM_REQ];
    logic [NUM_REQ-1:0] scan_valid;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign lane_data[gi]   = bus.req_data[8*gi +: 8];
        assign lane_parity[gi] = (^bus.req_data[8*gi +: 8]) ^ PARITY_ODD;
        // scan_idx[k] is the requester examined k-th, starting at the pointer.
        assign scan_idx[gi]    = ID_W'((int'(rr_q) + gi) % NUM_REQ);
        assign scan_valid[gi]  = bus.req_valid[scan_idx[gi]];
    end

    // First valid requester in scan order. Iterating downward lets the
    // lowest scan position overwrite any later one.
    logic            win_found;
    logic [ID_W-1:0] win_idx;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (scan_valid[k]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[k];
            end
        end
    end

    // Grants are offered only while idle and the PISO is idle as well.
    // reset_n gates the offer so req_ready is 0 for the whole reset.
    logic arb_open;
    logic accept;

    assign arb_open = reset_n && (state_q == IDLE) && bus.done_flag && !bus.active_flag;
    assign accept   = arb_open && win_found;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign bus.req_ready[gi] = accept && (win_idx == ID_W'(gi));
    end

    // -----------------------------------------------------------------------
    // Optional launch-timeout counter
    // -----------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_err_q, timeout_err_d;
    logic             launching;

    assign launching = (state_q == LOAD) || (state_q == WAIT_ACT);

    // The counter is zero on entry to LOAD and counts every launching cycle;
    // the abort fires on the TIMEOUT-th such cycle unless the PISO reports
    // active in WAIT_ACT (a late active_flag still wins over the abort).
    always_comb begin
        tmo_cnt_d     = '0;
        if (launching) begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
        timeout_hit   = launching
                        && !((state_q == WAIT_ACT) && bus.active_flag)
                        && (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
        timeout_err_d = timeout_err_q | timeout_hit;
    end

    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    assign timeout_hit     = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // FSM: next state and registered outputs
    // -----------------------------------------------------------------------
    // send_d is decoded from the next state so send is a clean flop output
    // that is high exactly while the FSM sits in LOAD or WAIT_ACT.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        parity_d = parity_q;
        send_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d   = lane_data[win_idx];
                    parity_d = lane_parity[win_idx];
                    grant_d  = win_idx;
                    rr_d     = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
                    state_d  = LOAD;
                    send_d   = 1'b1;
                end
            end
            LOAD: begin
                if (timeout_hit) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_ACT;
                    send_d  = 1'b1;
                end
            end
            WAIT_ACT: begin
                if (bus.active_flag) begin
                    state_d = WAIT_DONE;
                end else if (timeout_hit) begin
                    // Byte is dropped; the pointer already moved past it.
                    state_d = IDLE;
                end else begin
                    send_d  = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!bus.active_flag && bus.done_flag) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // data_q/parity_q are only rewritten on an accept, so the PISO sees a
    // stable frame even though it reloads every idle cycle.
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            grant_q  <= '0;
            data_q   <= 8'h00;
            parity_q <= PARITY_ODD;
            send_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            parity_q <= parity_d;
            send_q   <= send_d;
        end
    end

    assign bus.send       = send_q;
    assign bus.data_out   = data_q;
    assign bus.parity_out = parity_q;
    assign bus.grant_id   = grant_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;

    logic baud_clk = 1'b0;
    logic reset_n  = 1'b0;

    always #5 baud_clk = ~baud_clk;

    uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();
    uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus_odd ();

    uart_tx_arbiter #(.NUM_REQ(NREQ), .PARITY_ODD(1'b0), .TIMEOUT(16)) dut (
        .baud_clk (baud_clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    uart_tx_arbiter #(.NUM_REQ(NREQ), .PARITY_ODD(1'b1), .TIMEOUT(16)) dut_odd (
        .baud_clk (baud_clk),
        .reset_n  (reset_n),
        .bus      (bus_odd)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       par;
    } frame_t;

    int         checks = 0;
    int         errors = 0;
    int         frames_done = 0;
    int         ready_viol = 0;
    int         send_viol = 0;
    bit         piso_auto = 1'b0;
    frame_t     sb_q[$];
    logic [7:0] pend_q [NREQ][$];
    logic [NREQ-1:0] drv_acc;

    function automatic logic even_par(input logic [7:0] b);
        return ^b;
    endfunction

    function automatic frame_t mk(input int id, input logic [7:0] b);
        frame_t f;
        f.id   = 2'(id);
        f.data = b;
        f.par  = even_par(b);
        return f;
    endfunction

    // Requester driver: each requester presents the head of its own queue;
    // a byte is retired once valid&ready was seen before a clock edge.
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        drv_acc       = '0;
        forever begin
            @(negedge baud_clk);
            for (int i = 0; i < NREQ; i++) begin
                if (drv_acc[i] && pend_q[i].size() > 0) void'(pend_q[i].pop_front());
            end
            for (int i = 0; i < NREQ; i++) begin
                bus.req_valid[i]       = (pend_q[i].size() > 0);
                bus.req_data[8*i +: 8] = (pend_q[i].size() > 0) ? pend_q[i][0] : 8'h00;
            end
            #1;
            drv_acc = bus.req_valid & bus.req_ready;
            if (bus.busy && bus.req_ready != '0) ready_viol++;
            if ($countones(bus.req_ready) > 1) ready_viol++;
        end
    end

    // PISO model: launches a frame when it sees send, checks the frame
    // against the scoreboard, and holds active for a few cycles.
    initial begin
        frame_t exp_f;
        bus.active_flag = 1'b0;
        bus.done_flag   = 1'b1;
        forever begin
            @(negedge baud_clk);
            if (piso_auto && reset_n && bus.send) begin
                repeat (2) @(negedge baud_clk);
                bus.active_flag = 1'b1;
                bus.done_flag   = 1'b0;
                $display("frame id=%0d data=%h parity=%b send=%b", bus.grant_id, bus.data_out, bus.parity_out, bus.send);
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL frame_unexpected: got id=%0d data=%h, required no frame", bus.grant_id, bus.data_out);
                end else begin
                    exp_f = sb_q.pop_front();
                    if ({bus.grant_id, bus.data_out, bus.parity_out} !== {exp_f.id, exp_f.data, exp_f.par} || bus.send !== 1'b1) begin
                        errors++;
                        $display("FAIL frame: got id=%0d data=%h par=%b send=%b, required id=%0d data=%h par=%b send=1", bus.grant_id, bus.data_out, bus.parity_out, bus.send, exp_f.id, exp_f.data, exp_f.par);
                    end
                end
                repeat (4) begin
                    @(negedge baud_clk);
                    if (bus.send) send_viol++;
                end
                bus.active_flag = 1'b0;
                bus.done_flag   = 1'b1;
                frames_done++;
            end
        end
    end

    task automatic do_reset();
        for (int i = 0; i < NREQ; i++) pend_q[i].delete();
        piso_auto           = 1'b0;
        bus.active_flag     = 1'b0;
        bus.done_flag       = 1'b1;
        @(negedge baud_clk);
        reset_n = 1'b0;
        repeat (3) @(negedge baud_clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_frames(input int n, input string what);
        int target;
        int cyc;
        target = frames_done + n;
        cyc    = 0;
        while (frames_done < target && cyc < 400) begin
            @(negedge baud_clk);
            cyc++;
        end
        checks++;
        if (frames_done < target) begin
            errors++;
            $display("FAIL %s_frames: got %0d frames, required %0d", what, frames_done, target);
        end
        repeat (3) @(negedge baud_clk);
    endtask

    task automatic wait_send_high(input string what);
        int cyc;
        cyc = 0;
        do begin
            @(negedge baud_clk);
            #2;
            cyc++;
        end while (!bus.send && cyc < 50);
        checks++;
        if (!bus.send) begin
            errors++;
            $display("FAIL %s_send_wait: send=%b, required 1", what, bus.send);
        end
    endtask

    task automatic test_reset();
        @(negedge baud_clk);
        #2;
        checks++;
        if ({bus.send, bus.data_out, bus.parity_out, bus.grant_id, bus.busy, bus.timeout_err, bus.req_ready} !== {1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL reset_outputs: got send=%b data=%h par=%b id=%0d busy=%b terr=%b ready=%b, required all zero", bus.send, bus.data_out, bus.parity_out, bus.grant_id, bus.busy, bus.timeout_err, bus.req_ready);
        end
        checks++;
        if (bus_odd.parity_out !== 1'b1 || bus_odd.data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_odd_parity: got par=%b data=%h, required par=1 data=00", bus_odd.parity_out, bus_odd.data_out);
        end
    endtask

    task automatic test_single_request();
        int cyc;
        piso_auto = 1'b1;
        sb_q.push_back(mk(2, 8'hA5));
        pend_q[2].push_back(8'hA5);
        cyc = 0;
        do begin
            @(negedge baud_clk);
            #2;
            cyc++;
        end while (bus.req_ready == '0 && cyc < 20);
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready: got %b, required 0100", bus.req_ready);
        end
        @(negedge baud_clk);
        #2;
        checks++;
        if ({bus.req_ready, bus.send, bus.data_out, bus.parity_out, bus.grant_id, bus.busy} !== {4'b0000, 1'b1, 8'hA5, 1'b0, 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL single_launch: got ready=%b send=%b data=%h par=%b id=%0d busy=%b, required 0000 1 a5 0 2 1", bus.req_ready, bus.send, bus.data_out, bus.parity_out, bus.grant_id, bus.busy);
        end
        cyc = 0;
        do begin
            @(posedge baud_clk);
            cyc++;
        end while (!bus.active_flag && cyc < 20);
        #1;
        checks++;
        if (bus.send !== 1'b0 || bus.active_flag !== 1'b1) begin
            errors++;
            $display("FAIL single_send_drop: got send=%b active=%b, required send=0 active=1", bus.send, bus.active_flag);
        end
        wait_frames(1, "single");
        checks++;
        if (bus.busy !== 1'b0 || bus.data_out !== 8'hA5) begin
            errors++;
            $display("FAIL single_idle_hold: got busy=%b data=%h, required busy=0 data=a5", bus.busy, bus.data_out);
        end
    endtask

    task automatic test_reset_mid_frame();
        piso_auto = 1'b0;
        pend_q[1].push_back(8'h5A);
        wait_send_high("rst_act");
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.send, bus.busy, bus.data_out, bus.grant_id} !== {1'b0, 1'b0, 8'h00, 2'd0}) begin
            errors++;
            $display("FAIL reset_mid_launch: got send=%b busy=%b data=%h id=%0d, required 0 0 00 0", bus.send, bus.busy, bus.data_out, bus.grant_id);
        end
        @(negedge baud_clk);
        reset_n = 1'b1;
        pend_q[1].push_back(8'h5B);
        wait_send_high("rst_done");
        @(negedge baud_clk);
        bus.active_flag = 1'b1;
        bus.done_flag   = 1'b0;
        repeat (2) @(negedge baud_clk);
        #2;
        checks++;
        if (bus.busy !== 1'b1 || bus.send !== 1'b0) begin
            errors++;
            $display("FAIL wait_done_state: got busy=%b send=%b, required busy=1 send=0", bus.busy, bus.send);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.send !== 1'b0 || bus.data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_done: got busy=%b send=%b data=%h, required 0 0 00", bus.busy, bus.send, bus.data_out);
        end
        bus.active_flag = 1'b0;
        bus.done_flag   = 1'b1;
        @(negedge baud_clk);
        reset_n = 1'b1;
    endtask

    task automatic test_round_robin();
        piso_auto = 1'b1;
        ready_viol = 0;
        sb_q.push_back(mk(0, 8'h11));
        sb_q.push_back(mk(1, 8'h22));
        sb_q.push_back(mk(2, 8'h33));
        sb_q.push_back(mk(3, 8'h44));
        sb_q.push_back(mk(0, 8'h11));
        pend_q[0].push_back(8'h11);
        pend_q[0].push_back(8'h11);
        pend_q[1].push_back(8'h22);
        pend_q[2].push_back(8'h33);
        pend_q[3].push_back(8'h44);
        wait_frames(5, "round_robin");
        checks++;
        if (ready_viol != 0) begin
            errors++;
            $display("FAIL rr_ready_while_busy: got %0d violations, required 0", ready_viol);
        end
    endtask

    task automatic test_pointer_order();
        piso_auto = 1'b1;
        sb_q.push_back(mk(1, 8'h66));
        pend_q[1].push_back(8'h66);
        wait_frames(1, "ptr_setup");
        sb_q.push_back(mk(3, 8'h88));
        sb_q.push_back(mk(1, 8'h77));
        pend_q[1].push_back(8'h77);
        pend_q[3].push_back(8'h88);
        wait_frames(2, "ptr_pair");
        // Pointer should now rest at 2.
        sb_q.push_back(mk(2, 8'hA3));
        sb_q.push_back(mk(3, 8'hA4));
        sb_q.push_back(mk(0, 8'hA1));
        sb_q.push_back(mk(1, 8'hA2));
        for (int i = 0; i < NREQ; i++) pend_q[i].push_back(8'hA1 + 8'(i));
        wait_frames(4, "ptr_all");
    endtask

    task automatic odd_byte(input logic [7:0] b, input logic exp_par);
        @(negedge baud_clk);
        bus_odd.req_valid = 4'b0001;
        bus_odd.req_data  = {24'h0, b};
        #2;
        checks++;
        if (bus_odd.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL odd_ready_%h: got %b, required 0001", b, bus_odd.req_ready);
        end
        @(negedge baud_clk);
        bus_odd.req_valid = '0;
        #2;
        checks++;
        if ({bus_odd.send, bus_odd.data_out, bus_odd.parity_out} !== {1'b1, b, exp_par}) begin
            errors++;
            $display("FAIL odd_parity_%h: got send=%b data=%h par=%b, required 1 %h %b", b, bus_odd.send, bus_odd.data_out, bus_odd.parity_out, b, exp_par);
        end
        $display("odd frame data=%h parity=%b", bus_odd.data_out, bus_odd.parity_out);
        @(negedge baud_clk);
        bus_odd.active_flag = 1'b1;
        bus_odd.done_flag   = 1'b0;
        repeat (2) @(negedge baud_clk);
        bus_odd.active_flag = 1'b0;
        bus_odd.done_flag   = 1'b1;
        repeat (2) @(negedge baud_clk);
        #2;
        checks++;
        if (bus_odd.busy !== 1'b0) begin
            errors++;
            $display("FAIL odd_return_idle_%h: got busy=%b, required 0", b, bus_odd.busy);
        end
    endtask

    task automatic test_parity_odd();
        odd_byte(8'h03, 1'b1);
        odd_byte(8'h07, 1'b0);
        odd_byte(8'hA5, 1'b1);
    endtask

    task automatic test_launch_wait();
        int n;
        piso_auto = 1'b0;
        pend_q[0].push_back(8'hC3);
        wait_send_high("launch");
`ifdef ARB_TIMEOUT_EN
        n = 1;
        while (n < 64) begin
            @(negedge baud_clk);
            #2;
            if (!bus.send) break;
            n++;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL timeout_send_cycles: got %0d, required 16", n);
        end
        checks++;
        if (bus.timeout_err !== 1'b1 || bus.busy !== 1'b0 || bus.send !== 1'b0) begin
            errors++;
            $display("FAIL timeout_state: got terr=%b busy=%b send=%b, required 1 0 0", bus.timeout_err, bus.busy, bus.send);
        end
        piso_auto = 1'b1;
        sb_q.push_back(mk(1, 8'hE5));
        sb_q.push_back(mk(0, 8'hD4));
        pend_q[0].push_back(8'hD4);
        pend_q[1].push_back(8'hE5);
        wait_frames(2, "after_timeout");
        checks++;
        if (bus.timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got %b, required 1", bus.timeout_err);
        end
`else
        n = 0;
        repeat (40) begin
            @(negedge baud_clk);
            #2;
            if (bus.send && bus.busy && !bus.timeout_err) n++;
        end
        checks++;
        if (n != 40) begin
            errors++;
            $display("FAIL wait_act_hold: got %0d held cycles, required 40", n);
        end
        sb_q.push_back(mk(0, 8'hC3));
        piso_auto = 1'b1;
        wait_frames(1, "late_launch");
        sb_q.push_back(mk(1, 8'hE5));
        pend_q[1].push_back(8'hE5);
        wait_frames(1, "after_late");
        checks++;
        if (bus.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_tied_low: got %b, required 0", bus.timeout_err);
        end
`endif
    endtask

    task automatic test_final();
        checks++;
        if (sb_q.size() != 0 || send_viol != 0) begin
            errors++;
            $display("FAIL final_scoreboard: got %0d pending frames and %0d send-in-frame cycles, required 0 and 0", sb_q.size(), send_viol);
        end
    endtask

    initial begin
        bus_odd.req_valid   = '0;
        bus_odd.req_data    = '0;
        bus_odd.active_flag = 1'b0;
        bus_odd.done_flag   = 1'b1;
        do_reset();
        test_reset();
        test_single_request();
        test_reset_mid_frame();
        do_reset();
        test_round_robin();
        test_pointer_order();
        test_parity_odd();
        do_reset();
        test_launch_wait();
        test_final();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
